// File: rtl/miriscv_imem_responder_if.sv
// Fetch and load-port bundle of the instruction-memory responder.
//   slave  : memory side (miriscv_imem_responder)
//   master : requester side (core fetch unit plus boot/debug loader)
// Fetch channel : instr_req, instr_addr -> instr_rvalid, instr_rdata, instr_err
// Load channel  : ld_req, ld_addr, ld_wdata, ld_be -> ld_gnt
interface miriscv_imem_responder_if #(
  parameter int unsigned XLEN = 32
);
  logic              instr_req;
  logic [XLEN-1:0]   instr_addr;
  logic              instr_rvalid;
  logic [XLEN-1:0]   instr_rdata;
  logic              instr_err;

  logic              ld_req;
  logic [XLEN-1:0]   ld_addr;
  logic [XLEN-1:0]   ld_wdata;
  logic [XLEN/8-1:0] ld_be;
  logic              ld_gnt;

  modport slave (
    input  instr_req, instr_addr, ld_req, ld_addr, ld_wdata, ld_be,
    output instr_rvalid, instr_rdata, instr_err, ld_gnt
  );

  modport master (
    output instr_req, instr_addr, ld_req, ld_addr, ld_wdata, ld_be,
    input  instr_rvalid, instr_rdata, instr_err, ld_gnt
  );
endinterface

// File: rtl/miriscv_imem_responder.sv
// Instruction-memory responder: memory-side end of the miriscv fetch port.
// Returns the addressed RAM word LATENCY cycles after each fetch request.
// Misaligned or out-of-range fetches return ADDI x0,x0,0 with instr_err set.
// A byte-enabled load port fills the RAM whenever no fetch is requested.
// Ports:
//   clk_i   : clock, rising edge
//   arstn_i : asynchronous active-low reset (pipeline only, RAM keeps contents)
//   bus     : miriscv_imem_responder_if.slave (fetch + load channels)
module miriscv_imem_responder #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int unsigned     LATENCY     = 1
) (
  input  logic clk_i,
  input  logic arstn_i,
  miriscv_imem_responder_if.slave bus
);

  localparam int unsigned     AW  = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] ram [DEPTH_WORDS];

  // Fetch decode. The offset wraps, so addresses below BASE_ADDR would alias
  // high offsets; the explicit >= compare rejects them. BASE_ADDR is aligned
  // to the RAM size, so off[1:0] equals addr[1:0].
  logic [XLEN-1:0] f_off;
  logic            f_hit;
  logic [AW-1:0]   f_idx;

  assign f_off = bus.instr_addr - BASE_ADDR;
  assign f_idx = f_off[AW+1:2];
  assign f_hit = (bus.instr_addr >= BASE_ADDR) &&
                 (f_off[XLEN-1:AW+2] == '0) &&
                 (f_off[1:0] == 2'b00);

  // Load decode: low address bits are ignored, out-of-range writes dropped.
  logic [XLEN-1:0] l_off;
  logic            l_hit;
  logic [AW-1:0]   l_idx;
  logic            ram_we;
  logic            unused_ld_lsb;

  assign l_off         = bus.ld_addr - BASE_ADDR;
  assign l_idx         = l_off[AW+1:2];
  assign l_hit         = (bus.ld_addr >= BASE_ADDR) && (l_off[XLEN-1:AW+2] == '0);
  assign unused_ld_lsb = ^l_off[1:0];

  // Fetch owns the RAM port; a load only proceeds in a fetch-free cycle,
  // so read and write never collide.
  assign bus.ld_gnt = bus.ld_req & ~bus.instr_req;
  assign ram_we     = bus.ld_gnt & l_hit;

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int k = 0; k < XLEN/8; k++) begin
        if (bus.ld_be[k]) begin
          ram[l_idx][8*k +: 8] <= bus.ld_wdata[8*k +: 8];
        end
      end
    end
  end

  // Response pipeline. Stage 0 captures the RAM read (or the NOP substitute)
  // at the request edge; later stages just delay it. Data/err of a stage only
  // load behind a valid entry so the outputs hold their last response.
  logic            vld_q  [LATENCY];
  logic [XLEN-1:0] data_q [LATENCY];
  logic            err_q  [LATENCY];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      vld_q[0]  <= 1'b0;
      data_q[0] <= NOP;
      err_q[0]  <= 1'b0;
    end else begin
      vld_q[0] <= bus.instr_req;
      if (bus.instr_req) begin
        data_q[0] <= f_hit ? ram[f_idx] : NOP;
        err_q[0]  <= ~f_hit;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_stage
      always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
          vld_q[gi]  <= 1'b0;
          data_q[gi] <= NOP;
          err_q[gi]  <= 1'b0;
        end else begin
          vld_q[gi] <= vld_q[gi-1];
          if (vld_q[gi-1]) begin
            data_q[gi] <= data_q[gi-1];
            err_q[gi]  <= err_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign bus.instr_rvalid = vld_q[LATENCY-1];
  assign bus.instr_rdata  = data_q[LATENCY-1];
  assign bus.instr_err    = err_q[LATENCY-1];

endmodule

// File: tb/tb_miriscv_imem_responder.sv
// Bench for miriscv_imem_responder: three instances
//   u1 : LATENCY=1, BASE 0x0     (table-driven vectors, load priority)
//   u3 : LATENCY=3, BASE 0x0     (latency, gap pattern, mid-burst reset)
//   u2 : LATENCY=2, BASE 0x1000  (random traffic against a reference model)
module tb_miriscv_imem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE2 = 32'h0000_1000;
  localparam logic [31:0] NOPW  = 32'h0000_0013;
  localparam int          NRND  = 300;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  miriscv_imem_responder_if #(.XLEN(32)) if1 ();
  miriscv_imem_responder_if #(.XLEN(32)) if2 ();
  miriscv_imem_responder_if #(.XLEN(32)) if3 ();

  miriscv_imem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .LATENCY(1))
    u1 (.clk_i(clk), .arstn_i(rst_n), .bus(if1));
  miriscv_imem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE2), .LATENCY(2))
    u2 (.clk_i(clk), .arstn_i(rst_n), .bus(if2));
  miriscv_imem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .LATENCY(3))
    u3 (.clk_i(clk), .arstn_i(rst_n), .bus(if3));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vt [11];

  logic        pat_req [8];
  logic [31:0] pat_adr [8];
  logic [31:0] pat_dat [8];

  // reference model state for u2
  logic [31:0] mem2 [DEPTH];
  logic        rv [NRND+4];
  logic [31:0] rd [NRND+4];
  logic        re [NRND+4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    if1.instr_req = 0; if1.instr_addr = 0; if1.ld_req = 0; if1.ld_addr = 0; if1.ld_wdata = 0; if1.ld_be = 0;
    if2.instr_req = 0; if2.instr_addr = 0; if2.ld_req = 0; if2.ld_addr = 0; if2.ld_wdata = 0; if2.ld_be = 0;
    if3.instr_req = 0; if3.instr_addr = 0; if3.ld_req = 0; if3.ld_addr = 0; if3.ld_wdata = 0; if3.ld_be = 0;
  endtask

  // one load transaction into u1 and u3 simultaneously
  task automatic load13(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if1.instr_req = 0; if1.ld_req = 1; if1.ld_addr = a; if1.ld_wdata = d; if1.ld_be = be;
    if3.instr_req = 0; if3.ld_req = 1; if3.ld_addr = a; if3.ld_wdata = d; if3.ld_be = be;
    #1;
    chk("ld13_gnt_u1", if1.ld_gnt, 1);
    chk("ld13_gnt_u3", if3.ld_gnt, 1);
    step();
    if1.ld_req = 0; if3.ld_req = 0;
    $display("load u1/u3 addr=%h data=%h be=%b", a, d, be);
  endtask

  // fetch response the specification requires from u2 for one address
  function automatic void model_fetch(input logic [31:0] a, output logic [31:0] d, output logic e);
    logic [31:0] off;
    off = a - BASE2;
    if (a >= BASE2 && off < 4*DEPTH && a[1:0] == 2'b00) begin
      d = mem2[off/4];
      e = 1'b0;
    end else begin
      d = NOPW;
      e = 1'b1;
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_d;
    logic        last_e;
    logic        req, ldr;
    logic [31:0] fa, la, wd;
    logic [3:0]  be;
    logic [31:0] word;
    int          kind;

    idle_all();
    rst_n = 0;
    @(negedge clk);

    // ---------------- reset state ----------------
    if1.ld_req = 1; if1.ld_be = 4'b0000;
    if3.ld_req = 1; if3.instr_req = 1;
    #1;
    chk("rst_rvalid_u1", if1.instr_rvalid, 0);
    chk("rst_rdata_u1",  if1.instr_rdata, NOPW);
    chk("rst_err_u1",    if1.instr_err, 0);
    chk("rst_rvalid_u2", if2.instr_rvalid, 0);
    chk("rst_rdata_u2",  if2.instr_rdata, NOPW);
    chk("rst_rvalid_u3", if3.instr_rvalid, 0);
    chk("rst_rdata_u3",  if3.instr_rdata, NOPW);
    chk("rst_err_u3",    if3.instr_err, 0);
    chk("rst_gnt_u1",    if1.ld_gnt, 1);
    chk("rst_gnt_u3",    if3.ld_gnt, 0);
    $display("reset state sampled");
    idle_all();
    step();
    rst_n = 1;
    step();

    // ---------------- preload ----------------
    load13(32'h0, 32'h1111_1111, 4'hF);
    load13(32'h4, 32'h2222_2222, 4'hF);
    load13(32'h8, 32'h3333_3333, 4'hF);
    load13(32'hC, 32'h4444_4444, 4'hF);
    load13(32'h3C, 32'hCAFE_F00D, 4'hF);

    // ---------------- table vectors, LATENCY=1 ----------------
    vt[0]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h1111_1111, 1'b0};
    vt[1]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h2222_2222, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0008, 1'b1, 32'h3333_3333, 1'b0};
    vt[3]  = '{1'b1, 32'h0000_000C, 1'b1, 32'h4444_4444, 1'b0};
    vt[4]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h4444_4444, 1'b0};
    vt[5]  = '{1'b1, 32'h0000_0002, 1'b1, NOPW,          1'b1};
    vt[6]  = '{1'b1, 32'h0000_0040, 1'b1, NOPW,          1'b1};
    vt[7]  = '{1'b1, 32'h0000_003C, 1'b1, 32'hCAFE_F00D, 1'b0};
    vt[8]  = '{1'b0, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 1'b0};
    vt[9]  = '{1'b1, 32'hFFFF_FFFC, 1'b1, NOPW,          1'b1};
    vt[10] = '{1'b1, 32'h0000_0004, 1'b1, 32'h2222_2222, 1'b0};

    for (int i = 0; i < 11; i++) begin
      if1.instr_req  = vt[i].req;
      if1.instr_addr = vt[i].addr;
      step();
      chk($sformatf("vec%0d_vld", i),  if1.instr_rvalid, vt[i].vld);
      chk($sformatf("vec%0d_data", i), if1.instr_rdata,  vt[i].data);
      chk($sformatf("vec%0d_err", i),  if1.instr_err,    vt[i].err);
      $display("u1 vec%0d req=%0d addr=%h -> vld=%0d data=%h err=%0d",
               i, vt[i].req, vt[i].addr, if1.instr_rvalid, if1.instr_rdata, if1.instr_err);
    end
    if1.instr_req = 0;

    // ---------------- load/fetch priority ----------------
    if1.ld_req = 1; if1.ld_addr = 32'h0; if1.ld_wdata = 32'hAABB_CCDD; if1.ld_be = 4'b0010;
    if1.instr_req = 1; if1.instr_addr = 32'h8;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) if1.instr_req = 0;
      #1;
      chk($sformatf("prio_gnt%0d", k), if1.ld_gnt, (k == 2) ? 1 : 0);
      $display("u1 prio cycle %0d gnt=%0d", k, if1.ld_gnt);
      step();
      if (k < 2) chk($sformatf("prio_fetch%0d", k), if1.instr_rdata, 32'h3333_3333);
    end
    if1.ld_req = 0;
    if1.instr_req = 1; if1.instr_addr = 32'h0;
    step();
    chk("be_merge_data", if1.instr_rdata, 32'h1111_CC11);
    chk("be_merge_vld", if1.instr_rvalid, 1);
    $display("u1 byte-enable merge -> %h", if1.instr_rdata);
    if1.instr_req = 0;

    // ---------------- write then read next cycle ----------------
    load13(32'h14, 32'h5A5A_0005, 4'hF);
    if1.instr_req = 1; if1.instr_addr = 32'h14;
    step();
    chk("wr_rd_data", if1.instr_rdata, 32'h5A5A_0005);
    $display("u1 write-then-read idx5 -> %h", if1.instr_rdata);
    if1.instr_req = 0;

    // ---------------- LATENCY=3 single fetch ----------------
    if3.instr_req = 1; if3.instr_addr = 32'h8;
    for (int t = 0; t < 4; t++) begin
      step();
      if (t == 0) if3.instr_req = 0;
      chk($sformatf("l3_single_vld%0d", t), if3.instr_rvalid, (t == 2) ? 1 : 0);
      if (t == 2) chk("l3_single_data", if3.instr_rdata, 32'h3333_3333);
    end
    $display("u3 single fetch 0x8 -> %h", if3.instr_rdata);

    // ---------------- LATENCY=3 fetch/gap/fetch ----------------
    pat_req = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    pat_adr = '{32'h0, 32'h0, 32'h4, 32'hC, 32'h0, 32'h0, 32'h0, 32'h0};
    pat_dat = '{32'h1111_1111, 32'h0, 32'h2222_2222, 32'h4444_4444, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int t = 0; t < 8; t++) begin
      if3.instr_req = pat_req[t]; if3.instr_addr = pat_adr[t];
      step();
      if (t >= 2) begin
        chk($sformatf("l3_pat_vld%0d", t), if3.instr_rvalid, pat_req[t-2]);
        if (pat_req[t-2]) chk($sformatf("l3_pat_data%0d", t), if3.instr_rdata, pat_dat[t-2]);
      end else begin
        chk($sformatf("l3_pat_vld%0d", t), if3.instr_rvalid, 0);
      end
      $display("u3 pattern cycle %0d req=%0d vld=%0d data=%h", t, pat_req[t], if3.instr_rvalid, if3.instr_rdata);
    end

    // ---------------- reset mid-burst, LATENCY=3 ----------------
    for (int t = 0; t < 3; t++) begin
      if3.instr_req = 1; if3.instr_addr = 32'(4*t);
      step();
    end
    if3.instr_req = 0;
    chk("mid_pre_vld",  if3.instr_rvalid, 1);
    chk("mid_pre_data", if3.instr_rdata, 32'h1111_1111);
    rst_n = 0;
    #1;
    chk("mid_rst_vld",  if3.instr_rvalid, 0);
    chk("mid_rst_data", if3.instr_rdata, NOPW);
    chk("mid_rst_err",  if3.instr_err, 0);
    $display("u3 reset asserted mid-burst vld=%0d data=%h", if3.instr_rvalid, if3.instr_rdata);
    step();
    rst_n = 1;
    for (int t = 0; t < 5; t++) begin
      step();
      chk($sformatf("post_rst_vld%0d", t), if3.instr_rvalid, 0);
    end
    if3.instr_req = 1; if3.instr_addr = 32'h8;
    step();
    if3.instr_req = 0;
    step();
    chk("refetch_early_vld", if3.instr_rvalid, 0);
    step();
    chk("refetch_vld",  if3.instr_rvalid, 1);
    chk("refetch_data", if3.instr_rdata, 32'h3333_3333);
    $display("u3 re-fetch after reset 0x8 -> %h", if3.instr_rdata);

    // ---------------- random traffic on u2 ----------------
    for (int i = 0; i < DEPTH; i++) begin
      word = $urandom;
      if2.instr_req = 0; if2.ld_req = 1; if2.ld_addr = BASE2 + 32'(4*i); if2.ld_wdata = word; if2.ld_be = 4'hF;
      #1;
      chk("u2_fill_gnt", if2.ld_gnt, 1);
      mem2[i] = word;
      step();
    end
    if2.ld_req = 0;
    last_d = NOPW;
    last_e = 1'b0;

    for (int t = 0; t < NRND + 2; t++) begin
      req = 0; ldr = 0; fa = 0; la = 0; wd = 0; be = 0;
      if (t < NRND) begin
        req  = ($urandom_range(0, 9) < 7);
        kind = $urandom_range(0, 9);
        case (kind)
          6:       fa = BASE2 + 32'(4*$urandom_range(16, 20));
          7:       fa = BASE2 - 32'(4*$urandom_range(1, 4));
          8:       fa = BASE2 + 32'(4*$urandom_range(0, 15)) + 32'($urandom_range(1, 3));
          9:       fa = $urandom;
          default: fa = BASE2 + 32'(4*$urandom_range(0, 15));
        endcase
        ldr = $urandom_range(0, 1);
        la  = BASE2 - 32'd8 + 32'(4*$urandom_range(0, 21)) + 32'($urandom_range(0, 3));
        wd  = $urandom;
        be  = 4'($urandom_range(0, 15));
      end
      if2.instr_req = req; if2.instr_addr = fa;
      if2.ld_req = ldr; if2.ld_addr = la; if2.ld_wdata = wd; if2.ld_be = be;
      #1;
      chk("u2_gnt", if2.ld_gnt, ldr & ~req);

      rv[t] = req;
      model_fetch(fa, rd[t], re[t]);
      if (ldr && !req && la >= BASE2 && (la - BASE2) < 4*DEPTH) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) mem2[(la - BASE2) / 4][8*k +: 8] = wd[8*k +: 8];
      end

      step();
      // LATENCY=2: a request sampled at this edge appears one edge later
      if (t >= 1 && rv[t-1]) begin
        last_d = rd[t-1];
        last_e = re[t-1];
        chk("u2_vld", if2.instr_rvalid, 1);
        $display("u2 resp #%0d data=%h err=%0d", t-1, if2.instr_rdata, if2.instr_err);
      end else begin
        chk("u2_vld", if2.instr_rvalid, 0);
      end
      chk("u2_data", if2.instr_rdata, last_d);
      chk("u2_err",  if2.instr_err, last_e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/miriscv_imem_responder.md
# miriscv_imem_responder

Instruction-memory responder for the miriscv core: the memory-side end of the fetch interface. Accepts single-word fetch requests (req/addr), returns the addressed word after a fixed, parameterised latency with an rvalid strobe. Holds a word-addressed instruction RAM, plus a byte-enabled load port that a boot loader or debug block uses to fill it. Out-of-range and misaligned fetches return a NOP and flag an error, so the core never executes garbage.

## Interface
- XLEN, 32, data/address width (only 32 supported)
- DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two, ≥ 16)
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to 4·DEPTH_WORDS)
- LATENCY, 1, fetch request to rvalid latency in cycles (legal 1..4)

- clk_i  in  1  clock, all logic on rising edge
- arstn_i  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  fetch request, one word per asserted cycle
- instr_addr_i  in  XLEN  fetch byte address
- instr_rvalid_o  out  1  response valid
- instr_rdata_o  out  XLEN  response word
- instr_err_o  out  1  response is a substituted NOP (range/alignment error), coincident with rvalid
- ld_req_i  in  1  load-port write request
- ld_addr_i  in  XLEN  load byte address (word-aligned)
- ld_wdata_i  in  XLEN  load write data
- ld_be_i  in  XLEN/8  load byte enables
- ld_gnt_o  out  1  load write accepted this cycle (combinational)

## Operation
- Address decode: off = addr − BASE_ADDR (XLEN-bit, wraps); idx = off[XLEN-1:2]; in-range iff addr ≥ BASE_ADDR and idx < DEPTH_WORDS; aligned iff addr[1:0] == 0.
- Fetch: when instr_req_i=1, a request enters a LATENCY-deep response pipeline (valid, data, err per stage). Valid+aligned+in-range → RAM word; otherwise data = 32'h0000_0013 (ADDI x0,x0,0) and err=1. RAM is read in the request cycle's edge; remaining stages are plain registers.
- Back-to-back requests every cycle are accepted; throughput is one word per cycle; responses return strictly in order. No backpressure on the fetch side.
- Load: ld_gnt_o = ld_req_i & ~instr_req_i (fetch has priority). On grant, each byte lane with ld_be_i[k]=1 is written at idx of ld_addr_i; ld_addr_i[1:0] ignored. Out-of-range granted writes are dropped silently. Ungranted loads are not queued; the requester holds ld_req_i until granted.
- Write-then-read: a word written at edge N is returned by a fetch issued in the cycle after edge N. Read and write of the same cycle cannot occur (priority rule).
- RAM contents are not reset and survive reset.
- Between responses (instr_rvalid_o=0), instr_rdata_o and instr_err_o hold their last value.

## Timing
- Reset (arstn_i=0, asynchronous): all pipeline valid bits 0, data stages 32'h0000_0013, err stages 0. Outputs: instr_rvalid_o=0, instr_rdata_o=32'h0000_0013, instr_err_o=0; ld_gnt_o follows its combinational equation.
- Reset mid-operation: all in-flight responses discarded; no rvalid until LATENCY cycles after the first post-reset request.
- Request sampled at edge N → instr_rvalid_o/rdata/err valid in the cycle after edge N+LATENCY−1 (LATENCY=1: visible the cycle after the request).
- Gap in requests → rvalid deasserts exactly LATENCY cycles later, for as many cycles as the gap.
- ld_gnt_o has zero latency; write takes effect at the same edge.
- Address idx = DEPTH_WORDS−1 is last valid word; idx = DEPTH_WORDS errors; addr < BASE_ADDR errors (no wrap-around aliasing).

## Test plan
- Reset then LATENCY=1, preload idx 0..3 with 0x11111111..0x44444444 via load port, fetch 0x0,0x4,0x8,0xC back-to-back → rvalid 4 consecutive cycles starting one cycle after first req, data in order, err=0.
- LATENCY=3, single fetch of 0x8 → rvalid exactly 3 cycles after request, data 0x33333333; fetch/gap/fetch pattern → rvalid pattern identical shifted by 3.
- Fetch 0x2 (misaligned) and BASE_ADDR+4·DEPTH_WORDS (out of range) → data 0x00000013, err=1 on each; subsequent valid fetch err=0.
- ld_req_i and instr_req_i both high 2 cycles then instr_req_i low → ld_gnt_o 0,0,1; write with ld_be_i=4'b0010, wdata 0xAABBCCDD onto 0x11111111 → next fetch returns 0x1111CC11.
- Write idx 5 at edge N, fetch idx 5 in next cycle → new data returned.
- Assert arstn_i mid-burst with 2 responses in flight (LATENCY=3) → rvalid drops immediately, rdata=0x00000013, no stale rvalid after release; RAM contents unchanged on re-fetch.
